door_input_cond_1596: RTL and testbench

Input conditioning stage placed directly upstream of the door state machine `fsm_door_1596`. It synchronises and debounces the two push-button keys and the two end-position sensors. It resolves a simultaneous key press in favour of "up", generates one-cycle press pulses, and flags an implausible sensor combination. Its level outputs connect one-to-one to the `key_up`, `key_down`, `sense_up` and `sense_down` inputs of the door FSM.

---
 rtl/door_input_cond_1596.sv | 118 +++++++++++
 tb/tb_door_input_cond_1596.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/door_input_cond_1596.sv
// Input conditioning for the door FSM: synchronises and debounces the two keys
// and two limit switches, resolves key conflicts in favour of "up" and flags sensor faults.
module door_input_cond_1596 #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk2m,
    input  logic rst,
    input  logic key_up_raw,
    input  logic key_down_raw,
    input  logic sense_up_raw,
    input  logic sense_down_raw,
    output logic key_up,
    output logic key_down,
    output logic key_up_pulse,
    output logic key_down_pulse,
    output logic sense_up,
    output logic sense_down,
    output logic sense_fault
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0] raw_in;
    logic [3:0] stable_vec;

    assign raw_in = {sense_down_raw, sense_up_raw, key_down_raw, key_up_raw};

    // Channel order: 0 key_up, 1 key_down, 2 sense_up, 3 sense_down.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_chan
            logic [SYNC_STAGES-1:0] sync_q, sync_d;
            logic                   stable_q, stable_d;
            logic [CNT_W-1:0]       cnt_q, cnt_d;
            logic                   s;

            assign s = sync_q[SYNC_STAGES-1];

            always_comb begin
                sync_d   = {sync_q[SYNC_STAGES-2:0], raw_in[gi]};
                stable_d = stable_q;
                cnt_d    = cnt_q;
                if (s == stable_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_MAX) begin
                    stable_d = s;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk2m or posedge rst) begin
                if (rst) begin
                    sync_q   <= '0;
                    stable_q <= 1'b0;
                    cnt_q    <= '0;
                end else begin
                    sync_q   <= sync_d;
                    stable_q <= stable_d;
                    cnt_q    <= cnt_d;
                end
            end

            assign stable_vec[gi] = stable_q;
        end
    endgenerate

    logic key_up_q, key_up_d;
    logic key_down_q, key_down_d;
    logic key_up_pulse_q, key_up_pulse_d;
    logic key_down_pulse_q, key_down_pulse_d;
    logic sense_up_q, sense_up_d;
    logic sense_down_q, sense_down_d;
    logic sense_fault_q, sense_fault_d;

    // Pulses compare the next level against the registered one, so they
    // coincide with the level's rising edge.
    always_comb begin
        key_up_d         = stable_vec[0];
        key_down_d       = stable_vec[1] & ~stable_vec[0];
        key_up_pulse_d   = key_up_d & ~key_up_q;
        key_down_pulse_d = key_down_d & ~key_down_q;
        sense_up_d       = stable_vec[2];
        sense_down_d     = stable_vec[3];
        sense_fault_d    = stable_vec[2] & stable_vec[3];
    end

    always_ff @(posedge clk2m or posedge rst) begin
        if (rst) begin
            key_up_q         <= 1'b0;
            key_down_q       <= 1'b0;
            key_up_pulse_q   <= 1'b0;
            key_down_pulse_q <= 1'b0;
            sense_up_q       <= 1'b0;
            sense_down_q     <= 1'b0;
            sense_fault_q    <= 1'b0;
        end else begin
            key_up_q         <= key_up_d;
            key_down_q       <= key_down_d;
            key_up_pulse_q   <= key_up_pulse_d;
            key_down_pulse_q <= key_down_pulse_d;
            sense_up_q       <= sense_up_d;
            sense_down_q     <= sense_down_d;
            sense_fault_q    <= sense_fault_d;
        end
    end

    assign key_up         = key_up_q;
    assign key_down       = key_down_q;
    assign key_up_pulse   = key_up_pulse_q;
    assign key_down_pulse = key_down_pulse_q;
    assign sense_up       = sense_up_q;
    assign sense_down     = sense_down_q;
    assign sense_fault    = sense_fault_q;

endmodule

// File: tb/tb_door_input_cond_1596.sv
// Bench for door_input_cond_1596: directed scenarios plus random stimulus,
// all checked cycle by cycle against a sliding-window debounce reference.
module tb_door_input_cond_1596;

    localparam int SYNC = 2;
    localparam int DEB  = 8;

    logic       clk2m = 1'b0;
    logic       rst;
    logic [3:0] raw;
    logic       key_up, key_down, key_up_pulse, key_down_pulse;
    logic       sense_up, sense_down, sense_fault;

    wire [6:0] dout = {sense_fault, sense_down, sense_up, key_down_pulse,
                       key_up_pulse, key_down, key_up};

    door_input_cond_1596 #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk2m          (clk2m),
        .rst            (rst),
        .key_up_raw     (raw[0]),
        .key_down_raw   (raw[1]),
        .sense_up_raw   (raw[2]),
        .sense_down_raw (raw[3]),
        .key_up         (key_up),
        .key_down       (key_down),
        .key_up_pulse   (key_up_pulse),
        .key_down_pulse (key_down_pulse),
        .sense_up       (sense_up),
        .sense_down     (sense_down),
        .sense_fault    (sense_fault)
    );

    always #5 clk2m = ~clk2m;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference: raw delay line, window of the last DEB synchronised samples,
    // and a stable value that flips once the whole window disagrees with it.
    logic [SYNC-1:0] m_pipe [4];
    logic [DEB-1:0]  m_win  [4];
    logic            m_stable [4];
    logic [6:0]      m_out;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    endtask

    task automatic model_clear();
        for (int c = 0; c < 4; c++) begin
            m_pipe[c]   = '0;
            m_win[c]    = '0;
            m_stable[c] = 1'b0;
        end
        m_out = '0;
    endtask

    task automatic model_edge(input logic [3:0] r);
        logic [6:0] o;
        logic ku, kd, su, sd, s;
        ku = m_stable[0]; kd = m_stable[1]; su = m_stable[2]; sd = m_stable[3];
        o[0] = ku;
        o[1] = kd & ~ku;
        o[2] = ku & ~m_out[0];
        o[3] = o[1] & ~m_out[1];
        o[4] = su;
        o[5] = sd;
        o[6] = su & sd;
        for (int c = 0; c < 4; c++) begin
            s = m_pipe[c][SYNC-1];
            m_win[c] = {m_win[c][DEB-2:0], s};
            if (m_win[c] == {DEB{~m_stable[c]}}) m_stable[c] = ~m_stable[c];
            m_pipe[c] = {m_pipe[c][SYNC-2:0], r[c]};
        end
        m_out = o;
    endtask

    task automatic step();
        logic [3:0] r;
        r = raw;
        @(posedge clk2m);
        cyc++;
        if (!rst) model_edge(r);
        #1;
        check($sformatf("out@%0d", cyc), int'(dout), int'(m_out));
    endtask

    task automatic assert_rst();
        #2 rst = 1'b1;
        #1;
        model_clear();
        check("rst_async", int'(dout), 0);
    endtask

    task automatic release_rst();
        #3 rst = 1'b0;
    endtask

    task automatic wait_level(input int idx, input logic val, input int exp, input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (dout[idx] !== val && n < 40);
        check(tag, n, exp);
    endtask

    initial begin
        rst = 1'b1;
        raw = 4'h0;
        model_clear();
        repeat (3) step();
        release_rst();
        repeat (3) step();

        // 1: reset with all inputs high
        raw = 4'hF;
        repeat (20) step();
        assert_rst();
        repeat (3) step();
        release_rst();
        wait_level(0, 1'b1, 11, "s1_lat_key_up");
        check("s1_key_down", int'(key_down), 0);
        check("s1_fault", int'(sense_fault), 1);
        check("s1_pulse", int'(key_up_pulse), 1);
        step();
        check("s1_pulse_end", int'(key_up_pulse), 0);

        // 2: clean press and release
        raw = 4'h0;
        repeat (15) step();
        raw[0] = 1'b1;
        wait_level(0, 1'b1, 11, "s2_rise");
        check("s2_pulse", int'(key_up_pulse), 1);
        step();
        check("s2_pulse_end", int'(key_up_pulse), 0);
        raw[0] = 1'b0;
        wait_level(0, 1'b0, 11, "s2_fall");
        check("s2_no_pulse", int'(key_up_pulse), 0);

        // 3: bounce on key_down
        repeat (4) begin
            raw[1] = 1'b1;
            repeat (5) step();
            raw[1] = 1'b0;
            step();
        end
        check("s3_quiet", int'(key_down), 0);
        raw[1] = 1'b1;
        wait_level(1, 1'b1, 11, "s3_rise");

        // 4: conflict, up wins, down returns with a pulse
        raw[0] = 1'b1;
        wait_level(0, 1'b1, 11, "s4_up");
        check("s4_down_supp", int'(key_down), 0);
        raw[0] = 1'b0;
        wait_level(1, 1'b1, 11, "s4_down_back");
        check("s4_down_pulse", int'(key_down_pulse), 1);
        check("s4_up_low", int'(key_up), 0);

        // 5: sensor fault
        raw = 4'b1000;
        repeat (15) step();
        raw[2] = 1'b1;
        wait_level(6, 1'b1, 11, "s5_fault_set");
        check("s5_sense_up", int'(sense_up), 1);
        raw[3] = 1'b0;
        wait_level(6, 1'b0, 11, "s5_fault_clr");

        // 6: reset mid-debounce
        raw = 4'h0;
        repeat (15) step();
        raw[0] = 1'b1;
        repeat (5) step();
        assert_rst();
        repeat (2) step();
        release_rst();
        wait_level(0, 1'b1, 11, "s6_full_latency");

        // Random segments with occasional resets
        for (int i = 0; i < 200; i++) begin
            raw = 4'($urandom);
            repeat ($urandom_range(1, 25)) step();
            if ($urandom_range(0, 30) == 0) begin
                assert_rst();
                step();
                release_rst();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
